// File: rtl/axi_stream_egress_demux.sv
// axi_stream_egress_demux: steers whole AXI-Stream packets to one of up to
// four egress ports by tuser[1:0]; each port has its own beat FIFO.
module axi_stream_egress_demux #(
  parameter int DATA_SIZE           = 32,
  parameter int USER_SIZE           = 16,
  parameter int NUM_OF_EGRESS_PORTS = 3,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [DATA_SIZE-1:0]                   s_tdata,
  input  logic [DATA_SIZE/8-1:0]                 s_tkeep,
  input  logic                                   s_tlast,
  input  logic [USER_SIZE-1:0]                   s_tuser,
  output logic [NUM_OF_EGRESS_PORTS-1:0]         m_tvalid,
  input  logic [NUM_OF_EGRESS_PORTS-1:0]         m_tready,
  output logic [NUM_OF_EGRESS_PORTS*DATA_SIZE-1:0] m_tdata,
  output logic [NUM_OF_EGRESS_PORTS*DATA_SIZE/8-1:0] m_tkeep,
  output logic [NUM_OF_EGRESS_PORTS-1:0]         m_tlast,
  output logic [NUM_OF_EGRESS_PORTS*USER_SIZE-1:0] m_tuser,
  output logic [NUM_OF_EGRESS_PORTS*32-1:0]      fwd_pkt_cnt,
  output logic [31:0]                            drop_pkt_cnt
);

  localparam int KW = DATA_SIZE / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_SIZE + KW + 1 + USER_SIZE;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [USER_SIZE-1:0] user_q, user_d;
  logic [31:0]          drop_q, drop_d;

  logic [1:0]                     pid;
  logic                           pid_ok;
  logic                           accept;
  logic [3:0]                     full_x;
  logic [NUM_OF_EGRESS_PORTS-1:0] full;
  logic [NUM_OF_EGRESS_PORTS-1:0] push;
  logic [EW-1:0]                  entry;

  assign pid    = s_tuser[1:0];
  assign pid_ok = {1'b0, pid} < 3'(NUM_OF_EGRESS_PORTS);

  // Unused port slots read as full so they can never be selected.
  always_comb begin
    full_x = '1;
    for (int p = 0; p < NUM_OF_EGRESS_PORTS; p++) full_x[p] = full[p];
  end

  always_comb begin
    s_tready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE:    s_tready = pid_ok ? !full_x[pid] : 1'b1;
        FWD:     s_tready = !full_x[sel_q];
        default: s_tready = 1'b1;
      endcase
    end
  end

  assign accept = s_tvalid && s_tready;
  assign entry  = {s_tdata, s_tkeep, s_tlast,
                   (state_q == IDLE) ? s_tuser : user_q};

  always_comb begin
    for (int p = 0; p < NUM_OF_EGRESS_PORTS; p++) begin
      push[p] = accept &&
        (((state_q == IDLE) && pid_ok && (pid == 2'(p))) ||
         ((state_q == FWD) && (sel_q == 2'(p))));
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    user_d  = user_q;
    drop_d  = drop_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (pid_ok) begin
            sel_d  = pid;
            user_d = s_tuser;
            if (!s_tlast) state_d = FWD;
          end else if (s_tlast) begin
            drop_d = drop_q + 32'd1;
          end else begin
            state_d = DROP;
          end
        end
        FWD: if (s_tlast) state_d = IDLE;
        default: begin
          if (s_tlast) begin
            state_d = IDLE;
            drop_d  = drop_q + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      user_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      user_q  <= user_d;
      drop_q  <= drop_d;
    end
  end

  assign drop_pkt_cnt = drop_q;

  for (genvar p = 0; p < NUM_OF_EGRESS_PORTS; p++) begin : g_port
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   fwd_q;
    logic          valid;
    logic          pop;
    logic [EW-1:0] head;

    assign valid   = cnt_q != '0;
    assign full[p] = cnt_q == CW'(FIFO_DEPTH);
    assign pop     = valid && m_tready[p];
    // Zero the outputs while the port has nothing to offer.
    assign head    = valid ? mem_q[rd_q] : '0;

    assign m_tvalid[p] = valid;
    assign {m_tdata[p*DATA_SIZE +: DATA_SIZE],
            m_tkeep[p*KW +: KW],
            m_tlast[p],
            m_tuser[p*USER_SIZE +: USER_SIZE]} = head;
    assign fwd_pkt_cnt[p*32 +: 32] = fwd_q;

    always_ff @(posedge clk) begin
      if (push[p]) mem_q[wr_q] <= entry;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        fwd_q <= '0;
      end else begin
        if (push[p]) wr_q <= wr_q + 1'b1;
        if (pop)     rd_q <= rd_q + 1'b1;
        if (push[p] && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push[p]) cnt_q <= cnt_q - 1'b1;
        if (push[p] && entry[USER_SIZE]) fwd_q <= fwd_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_egress_demux.sv
// tb_axi_stream_egress_demux: directed and random packets checked against a
// per-port expected-beat queue model.
module tb_axi_stream_egress_demux;

  localparam int DW    = 32;
  localparam int UW    = 16;
  localparam int NP    = 3;
  localparam int KW    = DW / 8;
  localparam int BOUND = 100;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_tvalid;
  logic             s_tready;
  logic [DW-1:0]    s_tdata;
  logic [KW-1:0]    s_tkeep;
  logic             s_tlast;
  logic [UW-1:0]    s_tuser;
  logic [NP-1:0]    m_tvalid;
  logic [NP-1:0]    m_tready;
  logic [NP*DW-1:0] m_tdata;
  logic [NP*KW-1:0] m_tkeep;
  logic [NP-1:0]    m_tlast;
  logic [NP*UW-1:0] m_tuser;
  logic [NP*32-1:0] fwd_pkt_cnt;
  logic [31:0]      drop_pkt_cnt;

  int    tests = 0;
  int    failed = 0;
  beat_t exp_q [NP][$];
  int    fwd_exp [NP];
  int    drop_exp = 0;
  bit    mon_en = 0;
  bit    rnd_en = 0;
  int    rel_cnt = 0;

  axi_stream_egress_demux #(
    .DATA_SIZE(DW), .USER_SIZE(UW),
    .NUM_OF_EGRESS_PORTS(NP), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .fwd_pkt_cnt(fwd_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A beat pops at the next rising edge when valid and ready are both high.
  always begin
    @(negedge clk);
    #4;
    if (mon_en && rst_n) begin
      for (int p = 0; p < NP; p++) begin
        beat_t got;
        got = {m_tdata[p*DW +: DW], m_tkeep[p*KW +: KW],
               m_tlast[p], m_tuser[p*UW +: UW]};
        if (m_tvalid[p]) begin
          if (m_tready[p]) begin
            chk($sformatf("beat_expected_p%0d", p),
                64'(exp_q[p].size() > 0), 64'(1));
            if (exp_q[p].size() > 0) begin
              beat_t e;
              e = exp_q[p].pop_front();
              chk($sformatf("beat_p%0d", p), 64'(got), 64'(e));
            end
          end
        end else begin
          chk($sformatf("idle_zero_p%0d", p), 64'(got), 64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_en) m_tready = 3'($urandom);
    if (rel_cnt > 0) begin
      rel_cnt--;
      if (rel_cnt == 0) m_tready = '1;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [UW-1:0] u_wire,
                           input logic [UW-1:0] u_pkt, output int waits);
    int pid;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u_wire;
    waits    = 0;
    #1;
    while (!s_tready && waits < BOUND) begin
      tick();
      #1;
      waits++;
    end
    chk("accept_in_bound", 64'(s_tready), 64'(1));
    if (s_tready) begin
      @(posedge clk);
      pid = int'(u_pkt[1:0]);
      if (pid < NP) begin
        exp_q[pid].push_back({d, k, l, u_pkt});
        if (l) fwd_exp[pid]++;
      end else if (l) begin
        drop_exp++;
      end
    end
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [UW-1:0] u, input int len,
                          input logic [DW-1:0] base, output int wsum);
    int w;
    wsum = 0;
    for (int i = 0; i < len; i++) begin
      send_beat(base + DW'(i),
                (i == 0) ? 4'hF : 4'($urandom_range(1, 15)),
                i == len - 1,
                (i == 0) ? u : 16'($urandom), u, w);
      wsum += w;
    end
  endtask

  task automatic check_counters(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_fwd%0d", tag, p),
          64'(fwd_pkt_cnt[p*32 +: 32]), 64'(fwd_exp[p]));
      chk($sformatf("%s_qempty%0d", tag, p),
          64'(exp_q[p].size()), 64'(0));
    end
    chk({tag, "_drop"}, 64'(drop_pkt_cnt), 64'(drop_exp));
  endtask

  initial begin
    int w;
    for (int p = 0; p < NP; p++) fwd_exp[p] = 0;
    m_tready = '1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 16'h0005;
    s_tvalid = 1'b1;
    rst_n    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_mvalid", 64'(m_tvalid), 64'(0));
    chk("rst_mdata", 64'(|m_tdata), 64'(0));
    chk("rst_muser", 64'(|m_tuser), 64'(0));
    check_counters("rst");
    @(negedge clk);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;

    send_pkt(16'h0005, 4, 32'hA0, w);
    chk("route_waits", 64'(w), 64'(0));
    drain(6);
    check_counters("route");

    send_pkt(16'h0003, 3, 32'hB0, w);
    chk("drop_waits", 64'(w), 64'(0));
    drain(3);
    check_counters("drop");
    send_pkt(16'h0010, 1, 32'hC0, w);
    drain(3);
    check_counters("after_drop");

    m_tready = 3'b011;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'hD0 + 32'(i), 4'hF, 1'b0,
                (i == 0) ? 16'h0006 : 16'($urandom), 16'h0006, w);
      chk("bp_fill", 64'(w), 64'(0));
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'hD8;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    #1;
    chk("bp_stall0", 64'(s_tready), 64'(0));
    tick();
    #1;
    chk("bp_stall1", 64'(s_tready), 64'(0));
    m_tready[2] = 1'b1;
    send_beat(32'hD8, 4'hF, 1'b0, 16'($urandom), 16'h0006, w);
    chk("bp_resume", 64'(w), 64'(1));
    for (int i = 9; i < 12; i++) begin
      send_beat(32'hD0 + 32'(i), 4'hF, i == 11, 16'($urandom), 16'h0006, w);
    end
    drain(16);
    check_counters("bp");

    m_tready = 3'b110;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'hF0 + 32'(i), 4'hF, 1'b0,
                (i == 0) ? 16'h0020 : 16'($urandom), 16'h0020, w);
    end
    rel_cnt = 4;
    send_beat(32'hF8, 4'hF, 1'b0, 16'($urandom), 16'h0020, w);
    chk("hol_wait", 64'(w), 64'(5));
    send_beat(32'hF9, 4'hF, 1'b1, 16'($urandom), 16'h0020, w);
    send_pkt(16'h0021, 2, 32'h110, w);
    chk("iso_p1_waits", 64'(w), 64'(0));
    drain(12);
    for (int p = 0; p < NP; p++) begin
      send_pkt(16'h0030 | 16'(p), 1, 32'h200 + 32'(p), w);
      chk($sformatf("alt_waits%0d", p), 64'(w), 64'(0));
    end
    drain(4);
    check_counters("iso");

    m_tready = '0;
    send_beat(32'h300, 4'hF, 1'b0, 16'h0102, 16'h0102, w);
    send_beat(32'h301, 4'hF, 1'b0, 16'($urandom), 16'h0102, w);
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      fwd_exp[p] = 0;
    end
    drop_exp = 0;
    @(posedge clk);
    #1;
    chk("mrst_mvalid", 64'(m_tvalid), 64'(0));
    chk("mrst_tready", 64'(s_tready), 64'(0));
    check_counters("mrst");
    @(negedge clk);
    rst_n    = 1'b1;
    m_tready = '1;
    send_pkt(16'h0041, 2, 32'h400, w);
    chk("mrst_next_waits", 64'(w), 64'(0));
    drain(4);
    check_counters("mrst_next");

    rnd_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [UW-1:0] u;
      u = {14'($urandom), 2'($urandom_range(0, 3))};
      send_pkt(u, $urandom_range(1, 5), 32'(n) << 8, w);
    end
    rnd_en   = 1'b0;
    m_tready = '1;
    drain(30);
    check_counters("rand");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi_stream_egress_demux.md
# axi_stream_egress_demux

Per-packet AXI-Stream demultiplexer on the egress side of the queue manager. It takes the single merged stream, whose tuser carries {vlan_id, port_id}, and steers each whole packet to the egress port named by port_id. Each egress port has its own beat FIFO, so a stalled port does not corrupt packet framing on any other port. Packets with an out-of-range port_id are consumed and counted as drops.

## Interface
- DATA_SIZE, 32, tdata width in bits (multiple of 8)
- USER_SIZE, 16, tuser width; tuser[1:0] = port_id, tuser[USER_SIZE-1:2] = vlan_id
- NUM_OF_EGRESS_PORTS, 3, number of master ports (2..4, addressed by the 2-bit port_id)
- FIFO_DEPTH, 8, beats per egress FIFO (power of 2, ≥2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid && s_tready
- s_tdata  in  DATA_SIZE  input data
- s_tkeep  in  DATA_SIZE/8  input byte enables
- s_tlast  in  1  last beat of packet
- s_tuser  in  USER_SIZE  {vlan_id, port_id}; sampled on first beat only
- m_tvalid  out  NUM_OF_EGRESS_PORTS  per-port valid
- m_tready  in  NUM_OF_EGRESS_PORTS  per-port ready
- m_tdata  out  NUM_OF_EGRESS_PORTS*DATA_SIZE  port p at slice [p*DATA_SIZE +: DATA_SIZE]
- m_tkeep  out  NUM_OF_EGRESS_PORTS*DATA_SIZE/8  per-port byte enables
- m_tlast  out  NUM_OF_EGRESS_PORTS  per-port last
- m_tuser  out  NUM_OF_EGRESS_PORTS*USER_SIZE  per-port first-beat tuser, replicated on every beat of the packet
- fwd_pkt_cnt  out  NUM_OF_EGRESS_PORTS*32  packets written per port
- drop_pkt_cnt  out  32  packets dropped for an invalid port_id

## Operation
- FSM states:
  - IDLE: awaiting a first beat.
  - FWD: locked to port `sel`, with tuser latched in `cur_user`.
  - DROP: discarding the rest of a packet.
- IDLE, decode pid = s_tuser[1:0]:
  - pid < NUM_OF_EGRESS_PORTS: s_tready = !full[pid]. On accept, push {s_tdata, s_tkeep, s_tlast, s_tuser} to FIFO pid and latch sel = pid, cur_user = s_tuser. If !s_tlast go to FWD, otherwise stay in IDLE.
  - pid invalid: s_tready = 1. On accept, if s_tlast then drop_pkt_cnt++ and stay in IDLE, else go to DROP.
- FWD: s_tready = !full[sel]. On accept, push {s_tdata, s_tkeep, s_tlast, cur_user}; s_tuser is ignored. On an accepted tlast, return to IDLE.
- DROP: s_tready = 1. On an accepted tlast, drop_pkt_cnt++ and return to IDLE.
- fwd_pkt_cnt[p] increments on every push of a tlast beat into FIFO p.
- Both counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- Each egress FIFO:
  - Circular buffer with wrapping read/write pointers and a count of width $clog2(FIFO_DEPTH)+1.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - m_tvalid[p] = !empty. Pop on m_tvalid[p] && m_tready[p].
  - Push and pop in the same cycle leave count unchanged.
- While m_tvalid[p] = 0, m_tdata/m_tkeep/m_tlast/m_tuser for port p are driven 0.
- Ports are fully independent: backpressure on port q never affects port p ≠ q, except that s_tready stalls while the current packet targets a full port (head-of-line blocking, accepted by design).

## Timing
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE; all FIFOs empty; all counters 0.
  - All outputs 0 in the cycle after the reset edge.
  - s_tready is forced 0 while rst_n = 0.
- Reset mid-packet: partial packets in FIFOs and in flight are discarded. A downstream port may see m_tvalid fall without m_tlast; this is legal by design.
- Latency: a beat accepted at edge t appears on m_* after edge t (visible in cycle t+1). There is no combinational s_* to m_* path.
- s_tready is combinational from state, s_tuser (IDLE only) and registered full flags. It never depends on m_tready in the same cycle: there is no bypass, so a full FIFO being popped this cycle still blocks a push this cycle.
- Throughput: one beat per cycle per direction while neither side stalls.
- m_* are stable while m_tvalid && !m_tready (AXI rule), guaranteed by FIFO head registration.
- Back-to-back packets to different ports are accepted with no idle cycle between tlast and the next first beat.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with s_tvalid = 1 → s_tready = 0, m_tvalid = 0, all counters 0.
- Routing: 4-beat packet, tuser = 0x0005 (vlan 1, port 1), data 0xA0..0xA3 → port 1 only emits A0..A3 with tlast on A3 and m_tuser = 0x0005 on every beat; fwd_pkt_cnt[1] = 1; ports 0 and 2 stay idle.
- Invalid port: 3-beat packet with tuser[1:0] = 3 → s_tready = 1 throughout; no m_tvalid on any port; drop_pkt_cnt = 1. A following 1-beat packet to port 0 is delivered with tlast.
- Backpressure: m_tready[2] = 0, 12-beat packet to port 2 → exactly 8 beats accepted, then s_tready = 0. Releasing m_tready[2] delivers all 12 beats in order, and s_tready resumes the cycle after the first pop.
- Isolation: m_tready[0] = 0 with FIFO 0 full, then a packet to port 1 → port 1 receives its packet only after the port-0 packet fully drains (head-of-line). With m_tready[0] = 1 and alternating 1-beat packets to ports 0, 1, 2 → one beat accepted per cycle and counters reach 1/1/1 after 3 packets.
- Reset mid-packet: assert rst_n = 0 after beat 2 of a 5-beat packet → FIFO emptied, m_tvalid = 0 next cycle, FSM back in IDLE; the next packet is routed by its own tuser.
